// File: rtl/iosc_ctrl.sv
`timescale 1ns/1ps
// iosc_ctrl: services the IOSC units (INS_PC, INS_AR, OTH) on the unit-enable bus by
// running one req/ack transaction on the external memory/peripheral port per request.
module iosc_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned TIMEOUT    = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [15:0]           i_unit_ien,
   input  logic [15:0]           i_unit_oen,
   input  logic [ADDR_WIDTH-1:0] i_pc,
   input  logic [ADDR_WIDTH-1:0] i_ar,
   input  logic [DATA_WIDTH-1:0] i_bus_data,
   output logic [DATA_WIDTH-1:0] o_bus_data,
   output logic                  o_bus_valid,
   output logic                  o_busy,
   output logic                  o_done,
   output logic                  o_err,
   output logic                  o_pc_inc,
   output logic                  o_mem_req,
   output logic                  o_mem_we,
   output logic                  o_mem_sel,
   output logic [ADDR_WIDTH-1:0] o_mem_addr,
   output logic [DATA_WIDTH-1:0] o_mem_wdata,
   input  logic                  i_mem_ack,
   input  logic [DATA_WIDTH-1:0] i_mem_rdata
);

   localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic             rd_q;
   logic             pc_q;

   logic [2:0] oen_hit;
   logic [2:0] ien_hit;
   logic [2:0] unit_vec;
   logic       trig;
   logic       illegal;
   logic       rd_req;
   logic       pick_pc;
   logic       pick_oth;
   logic       unused_enables;

   // Core-register and spare enable bits belong to other responders.
   assign unused_enables = ^{i_unit_oen[15:14], i_unit_oen[10:0],
                             i_unit_ien[15:14], i_unit_ien[10:0]};

   // Request decode; a legal request has IOSC bits in only one vector, so OR-ing
   // them yields that vector, and the lowest set bit picks the unit.
   always_comb begin
      oen_hit  = i_unit_oen[13:11];
      ien_hit  = i_unit_ien[13:11];
      unit_vec = oen_hit | ien_hit;
      trig     = |unit_vec;
      illegal  = (|oen_hit) && (|ien_hit);
      rd_req   = |oen_hit;
      pick_pc  = unit_vec[0];
      pick_oth = !unit_vec[0] && !unit_vec[1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= ST_IDLE;
         cnt         <= '0;
         rd_q        <= 1'b0;
         pc_q        <= 1'b0;
         o_bus_data  <= '0;
         o_bus_valid <= 1'b0;
         o_busy      <= 1'b0;
         o_done      <= 1'b0;
         o_err       <= 1'b0;
         o_pc_inc    <= 1'b0;
         o_mem_req   <= 1'b0;
         o_mem_we    <= 1'b0;
         o_mem_sel   <= 1'b0;
         o_mem_addr  <= '0;
         o_mem_wdata <= '0;
      end else begin
         o_bus_valid <= 1'b0;
         o_done      <= 1'b0;
         o_err       <= 1'b0;
         o_pc_inc    <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (trig) begin
                  o_busy <= 1'b1;
                  if (illegal) begin
                     state  <= ST_DONE;
                     o_done <= 1'b1;
                     o_err  <= 1'b1;
                     rd_q   <= 1'b0;
                     pc_q   <= 1'b0;
                  end else begin
                     state       <= ST_REQ;
                     cnt         <= '0;
                     o_mem_req   <= 1'b1;
                     o_mem_we    <= !rd_req;
                     o_mem_sel   <= pick_oth;
                     o_mem_addr  <= pick_pc ? i_pc : i_ar;
                     o_mem_wdata <= i_bus_data;
                     rd_q        <= rd_req;
                     pc_q        <= rd_req && pick_pc;
                  end
               end
            end
            ST_REQ: begin
               // Ack on the final counted cycle still completes without error.
               if (i_mem_ack || (cnt == CNT_LAST)) begin
                  state       <= ST_DONE;
                  cnt         <= '0;
                  o_mem_req   <= 1'b0;
                  o_done      <= 1'b1;
                  o_err       <= !i_mem_ack;
                  o_bus_valid <= rd_q;
                  o_pc_inc    <= pc_q;
                  if (rd_q) begin
                     o_bus_data <= i_mem_ack ? i_mem_rdata : '0;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_DONE: begin
               state  <= ST_IDLE;
               o_busy <= 1'b0;
            end
            default: begin
               state     <= ST_IDLE;
               o_busy    <= 1'b0;
               o_mem_req <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: doc/iosc_ctrl.md
Name: iosc_ctrl

Overview:
- Responder side of the unit-enable bus: consumes the 16-bit one-hot input-enable (target) and output-enable (source) vectors from the instruction decoder.
- Services the three IOSC units (bit 11 INS_PC, bit 12 INS_AR, bit 13 OTH) by running a req/ack transaction on the external memory/peripheral port.
- Read data goes back onto the core data bus; bus data is written out to memory/peripheral.
- Sits between the core data bus and external storage; core-register bits (0-8) are ignored here.

Parameters:
DATA_WIDTH, 8, core bus / memory data width
ADDR_WIDTH, 8, external address width
TIMEOUT, 16, max cycles waiting for i_mem_ack before abort (>=2)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-high reset
i_unit_ien  in  16  one-hot target enables from decoder (IOSC receives bus data)
i_unit_oen  in  16  one-hot source enables from decoder (IOSC drives bus data)
i_pc  in  ADDR_WIDTH  current program counter
i_ar  in  ADDR_WIDTH  current address register
i_bus_data  in  DATA_WIDTH  core bus data (write source)
o_bus_data  out  DATA_WIDTH  read data to core bus
o_bus_valid  out  1  o_bus_data valid, 1-cycle pulse
o_busy  out  1  transaction in progress
o_done  out  1  transaction complete, 1-cycle pulse
o_err  out  1  timeout or illegal request, 1-cycle pulse
o_pc_inc  out  1  request PC increment after INS_PC read, 1-cycle pulse
o_mem_req  out  1  external request
o_mem_we  out  1  1=write, 0=read
o_mem_sel  out  1  0=instruction/data memory, 1=other device (OTH)
o_mem_addr  out  ADDR_WIDTH  external address
o_mem_wdata  out  DATA_WIDTH  external write data
i_mem_ack  in  1  external acknowledge (one cycle, data valid for reads)
i_mem_rdata  in  DATA_WIDTH  external read data

Behaviour:
- Reset (async, immediate): all outputs 0, state IDLE, counter 0; an in-flight request is abandoned with o_mem_req dropped at once.
- States: IDLE, REQ, DONE.
- IDLE, trigger: any of bits 13:11 set in i_unit_oen or i_unit_ien is sampled at edge N.
  - Read if oen hit, write if ien hit.
  - Multiple IOSC bits in one vector: lowest bit wins (INS_PC > INS_AR > OTH).
- Address select: INS_PC -> i_pc, sel=0. INS_AR -> i_ar, sel=0. OTH -> i_ar, sel=1.
- Write data: i_bus_data is latched at edge N into o_mem_wdata.
- IOSC bit set in both oen and ien at the same edge (IOSC->IOSC): illegal.
  - No request; go to DONE; o_err=1, o_done=1, o_bus_valid=0.
- REQ, entered at N+1:
  - o_mem_req=1, o_busy=1.
  - addr/we/sel/wdata held stable until ack is sampled.
  - Counter starts at 0 and increments each cycle without ack.
- Ack sampled high in REQ:
  - o_mem_req drops on the next cycle; go to DONE.
  - Read: latch i_mem_rdata into o_bus_data.
- Timeout: counter reaches TIMEOUT-1 with no ack -> drop req, go to DONE with o_err=1.
  - Read: o_bus_data=0, so the core never hangs.
  - Ack in the same cycle as timeout: ack wins, no error.
- DONE (one cycle), then unconditionally back to IDLE:
  - o_done=1, o_busy=1.
  - Read: o_bus_valid=1.
  - INS_PC read only: o_pc_inc=1, including the timeout case.
- Minimum transaction (ack in first REQ cycle): sample N, req N+1, DONE N+2, next sample possible at edge N+3.
- Enables present while not IDLE are ignored; the decoder must hold or reissue them.
- i_mem_ack outside REQ is ignored.
- o_bus_data holds its last value between reads; it is meaningful only while o_bus_valid=1.

Test Plan:
- INS_PC read: i_pc=0x10, oen=0x0800; ack on the first REQ cycle with rdata=0xA5 -> req high 1 cycle at addr 0x10, we=0, sel=0; next cycle o_bus_valid=1, o_bus_data=0xA5, o_pc_inc=1, o_done=1.
- AR write: i_ar=0x3C, ien=0x1000, i_bus_data=0x5A; ack delayed 3 cycles -> req held 4 cycles with addr 0x3C, we=1, wdata=0x5A stable; o_done pulse, o_bus_valid=0, o_pc_inc=0.
- OTH read timeout: oen=0x2000, TIMEOUT=16, no ack -> req high exactly 16 cycles, sel=1; then o_err=1, o_bus_valid=1, o_bus_data=0x00; back to IDLE.
- Illegal request: oen=0x0800, ien=0x1000 in the same cycle -> no req; one cycle later o_err=1, o_done=1.
- Ack on the timeout cycle: ack arrives on REQ cycle 16 with rdata=0x77 -> o_err=0, o_bus_data=0x77.
- Reset mid-op: assert rst during REQ cycle 2 -> o_mem_req, o_busy, o_done, o_err and o_bus_valid drop immediately; after release, a new oen=0x0800 transaction completes normally.
